// File: rtl/bitplane_serializer.sv
// Captures one operand vector and streams it MSB-first as VEC_LENGTH-bit bit-planes,
// optionally skipping all-zero planes so the bit-serial PE array never idles on them.
module bitplane_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LENGTH = 8,
    parameter int ZERO_SKIP  = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         d_in [VEC_LENGTH-1:0],
    input  logic                          load_valid,
    output logic                          load_ready,
    output logic [VEC_LENGTH-1:0]         bp_out,
    output logic [$clog2(DATA_WIDTH)-1:0] bp_idx,
    output logic                          bp_valid,
    input  logic                          bp_ready,
    output logic                          bp_last,
    output logic                          busy
);

    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q [VEC_LENGTH-1:0];
    logic [DATA_WIDTH-1:0] data_d [VEC_LENGTH-1:0];
    logic [IDX_W-1:0]      idx_q, idx_d;

    logic [DATA_WIDTH-1:0] nz_cur, nz_in;
    logic [VEC_LENGTH-1:0] plane;
    logic                  start_found, next_found, last_plane;
    logic [IDX_W-1:0]      start_idx, next_idx;

    // Returns {found, index} of the highest set mask bit strictly below limit.
    function automatic logic [IDX_W:0] highest_below(input logic [DATA_WIDTH-1:0] mask,
                                                     input int limit);
        logic             found;
        logic [IDX_W-1:0] hi;
        found = 1'b0;
        hi    = '0;
        for (int k = 0; k < DATA_WIDTH; k++) begin
            if (mask[k] && (k < limit)) begin
                found = 1'b1;
                hi    = IDX_W'(k);
            end
        end
        return {found, hi};
    endfunction

    // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
    always_comb begin
        nz_cur = '0;
        nz_in  = '0;
        plane  = '0;
        for (int j = 0; j < VEC_LENGTH; j++) begin
            nz_cur   = nz_cur | data_q[j];
            nz_in    = nz_in | d_in[j];
            plane[j] = data_q[j][idx_q];
        end

        // An all-zero vector starts (and ends) at index 0 so the consumer still gets a last plane.
        {start_found, start_idx} = highest_below(nz_in, DATA_WIDTH);
        {next_found, next_idx}   = highest_below(nz_cur, int'(idx_q));
        last_plane = (ZERO_SKIP != 0) ? !next_found : (idx_q == '0);

        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;

        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    data_d  = d_in;
                    idx_d   = (ZERO_SKIP != 0) ? start_idx : TOP_IDX;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bp_ready) begin
                    if (last_plane) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = (ZERO_SKIP != 0) ? next_idx : (idx_q - IDX_W'(1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        load_ready = (state_q == IDLE);
        busy       = (state_q == SHIFT);
        bp_valid   = busy;
        bp_out     = busy ? plane : '0;
        bp_idx     = busy ? idx_q : '0;
        bp_last    = busy && last_plane;
    end

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            // NOTE: the captured vector is cleared on reset so no stale operand is ever visible.
            for (int j = 0; j < VEC_LENGTH; j++) begin
                data_q[j] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    // The start-index search is only consumed in zero-skip mode; start_found is informational.
    logic unused_start_found;
    assign unused_start_found = start_found;

endmodule

// File: tb/tb_bitplane_serializer.sv
// Drives a full-plane instance and a zero-skip instance, checking every cycle of each
// stream against a plane list computed directly from the operand vector.
module tb_bitplane_serializer;

    localparam int DW = 8;
    localparam int VL = 4;

    typedef logic [DW-1:0] vec_t [VL-1:0];
    typedef struct {
        logic [VL-1:0] out;
        logic [2:0]    idx;
        logic          last;
    } plane_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] d_in0 [VL-1:0];
    logic [DW-1:0] d_in1 [VL-1:0];
    logic          lv0, lv1, rdy0, rdy1;
    logic          lr0, lr1, v0, v1, last0, last1, busy0, busy1;
    logic [VL-1:0] out0, out1;
    logic [2:0]    idx0, idx1;

    int n_checks = 0;
    int n_fail   = 0;

    plane_t exp_q[$];
    plane_t obs_q[$];

    always #5 clk = ~clk;

    bitplane_serializer #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .ZERO_SKIP(0)) u_full (
        .clk(clk), .reset(reset), .d_in(d_in0), .load_valid(lv0), .load_ready(lr0),
        .bp_out(out0), .bp_idx(idx0), .bp_valid(v0), .bp_ready(rdy0), .bp_last(last0),
        .busy(busy0)
    );

    bitplane_serializer #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .ZERO_SKIP(1)) u_skip (
        .clk(clk), .reset(reset), .d_in(d_in1), .load_valid(lv1), .load_ready(lr1),
        .bp_out(out1), .bp_idx(idx1), .bp_valid(v1), .bp_ready(rdy1), .bp_last(last1),
        .busy(busy1)
    );

    task automatic drive_load(input int sel, input logic lv, input vec_t vec);
        if (sel == 0) begin
            lv0 = lv;
            for (int j = 0; j < VL; j++) d_in0[j] = vec[j];
        end else begin
            lv1 = lv;
            for (int j = 0; j < VL; j++) d_in1[j] = vec[j];
        end
    endtask

    task automatic set_lv(input int sel, input logic lv);
        if (sel == 0) lv0 = lv;
        else lv1 = lv;
    endtask

    task automatic set_ready(input int sel, input logic r);
        if (sel == 0) rdy0 = r;
        else rdy1 = r;
    endtask

    task automatic observe(input int sel, output plane_t o, output logic v, output logic lr,
                           output logic b);
        if (sel == 0) begin
            o.out = out0; o.idx = idx0; o.last = last0; v = v0; lr = lr0; b = busy0;
        end else begin
            o.out = out1; o.idx = idx1; o.last = last1; v = v1; lr = lr1; b = busy1;
        end
    endtask

    function automatic vec_t rand_vec(input bit sparse);
        vec_t    v;
        logic [DW-1:0] mask;
        mask = sparse ? DW'($urandom) : '1;
        for (int j = 0; j < VL; j++) v[j] = DW'($urandom) & mask;
        return v;
    endfunction

    // Expected stream: scan significances high to low, keep each plane unless skipping zeros.
    task automatic build_model(input bit zs, input vec_t vec);
        plane_t p;
        exp_q.delete();
        for (int k = DW - 1; k >= 0; k--) begin
            p.out  = '0;
            p.idx  = 3'(k);
            p.last = 1'b0;
            for (int j = 0; j < VL; j++) p.out[j] = vec[j][k];
            if (!zs || (p.out != '0)) exp_q.push_back(p);
        end
        if (exp_q.size() == 0) begin
            p.out = '0; p.idx = '0; p.last = 1'b0;
            exp_q.push_back(p);
        end
        exp_q[exp_q.size() - 1].last = 1'b1;
    endtask

    // Loads vec at the current negedge, then consumes the whole stream with the given
    // ready pattern (0: always, 1: 1,0,0 repeating, 2: random). With hold set, load_valid
    // stays high with junk data throughout and is left high on return.
    task automatic run_vector(input int sel, input vec_t vec, input int mode, input bit hold);
        plane_t o;
        logic   v, lr, b, r;
        int     cyc;
        bit     done;
        build_model(sel == 1, vec);
        obs_q.delete();
        drive_load(sel, 1'b1, vec);
        set_ready(sel, 1'b0);
        @(posedge clk);
        @(negedge clk);
        cyc  = 0;
        done = 1'b0;
        while (!done) begin
            observe(sel, o, v, lr, b);
            n_checks++;
            if (exp_q.size() == 0) begin
                if ({v, lr, b, o.out, o.last} !== {1'b0, 1'b1, 1'b0, {VL{1'b0}}, 1'b0}) begin
                    n_fail++;
                    $display("FAIL idle_after_last dut%0d: valid=%b load_ready=%b busy=%b out=%b last=%b, required 0 1 0 0000 0",
                             sel, v, lr, b, o.out, o.last);
                end
                done = 1'b1;
            end else begin
                if ({v, lr, o.out, o.idx, o.last} !==
                    {1'b1, 1'b0, exp_q[0].out, exp_q[0].idx, exp_q[0].last}) begin
                    n_fail++;
                    $display("FAIL plane dut%0d cyc%0d: valid=%b load_ready=%b out=%b idx=%0d last=%b, required 1 0 %b %0d %b",
                             sel, cyc, v, lr, o.out, o.idx, o.last,
                             exp_q[0].out, exp_q[0].idx, exp_q[0].last);
                end
                case (mode)
                    0:       r = 1'b1;
                    1:       r = (cyc % 3 == 0);
                    default: r = 1'($urandom_range(0, 1));
                endcase
                set_ready(sel, r);
                if (r) begin
                    obs_q.push_back(o);
                    void'(exp_q.pop_front());
                end
                if (hold) drive_load(sel, 1'b1, rand_vec(1'b0));
                else set_lv(sel, 1'b0);
                cyc++;
                if (cyc > 200) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stream_timeout dut%0d: %0d planes outstanding, required 0",
                             sel, exp_q.size());
                    exp_q.delete();
                    done = 1'b1;
                end
                if (!done) @(negedge clk);
            end
        end
        set_ready(sel, 1'b0);
        if (!hold) set_lv(sel, 1'b0);
    endtask

    task automatic test_reset();
        vec_t z;
        for (int j = 0; j < VL; j++) z[j] = '0;
        reset = 1'b1;
        drive_load(0, 1'b0, z);
        drive_load(1, 1'b0, z);
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            plane_t o;
            logic   v, lr, b;
            observe(s, o, v, lr, b);
            n_checks++;
            if ({lr, v, b, o.out, o.idx, o.last} !== {1'b1, 1'b0, 1'b0, {VL{1'b0}}, 3'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: load_ready=%b valid=%b busy=%b out=%b idx=%0d last=%b, required 1 0 0 0000 0 0",
                         s, lr, v, b, o.out, o.idx, o.last);
            end
        end
    endtask

    task automatic test_full_stream();
        vec_t vec;
        vec[0] = 8'h81; vec[1] = 8'h01; vec[2] = 8'h80; vec[3] = 8'hFF;
        run_vector(0, vec, 0, 1'b0);
        n_checks++;
        if (obs_q.size() != 8) begin
            n_fail++;
            $display("FAIL full_count: %0d transfers, required 8", obs_q.size());
        end else begin
            n_checks++;
            if ({obs_q[0].out, obs_q[0].idx} !== {4'b1101, 3'd7}) begin
                n_fail++;
                $display("FAIL full_idx7: out=%b idx=%0d, required 1101 7", obs_q[0].out, obs_q[0].idx);
            end
            for (int i = 1; i < 7; i++) begin
                n_checks++;
                if (obs_q[i].out !== 4'b1000) begin
                    n_fail++;
                    $display("FAIL full_mid plane%0d: out=%b, required 1000", i, obs_q[i].out);
                end
            end
            n_checks++;
            if ({obs_q[7].out, obs_q[7].idx, obs_q[7].last} !== {4'b1011, 3'd0, 1'b1}) begin
                n_fail++;
                $display("FAIL full_idx0: out=%b idx=%0d last=%b, required 1011 0 1",
                         obs_q[7].out, obs_q[7].idx, obs_q[7].last);
            end
        end
    endtask

    task automatic test_stall();
        vec_t vec;
        vec[0] = 8'h81; vec[1] = 8'h01; vec[2] = 8'h80; vec[3] = 8'hFF;
        run_vector(0, vec, 1, 1'b0);
        n_checks++;
        if (obs_q.size() != 8) begin
            n_fail++;
            $display("FAIL stall_count: %0d transfers, required 8", obs_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if ({obs_q[i].idx, obs_q[i].last} !== {3'(7 - i), 1'(i == 7)}) begin
                    n_fail++;
                    $display("FAIL stall_order transfer%0d: idx=%0d last=%b, required %0d %b",
                             i, obs_q[i].idx, obs_q[i].last, 7 - i, (i == 7));
                end
            end
        end
    endtask

    task automatic test_zero_skip();
        vec_t vec;
        vec[0] = 8'h05; vec[1] = 8'h00; vec[2] = 8'h04; vec[3] = 8'h01;
        run_vector(1, vec, 0, 1'b0);
        n_checks++;
        if (obs_q.size() != 2) begin
            n_fail++;
            $display("FAIL skip_count: %0d transfers, required 2", obs_q.size());
        end else begin
            n_checks++;
            if ({obs_q[0].out, obs_q[0].idx, obs_q[0].last, obs_q[1].out, obs_q[1].idx, obs_q[1].last}
                !== {4'b0101, 3'd2, 1'b0, 4'b1001, 3'd0, 1'b1}) begin
                n_fail++;
                $display("FAIL skip_planes: %b/%0d/%b then %b/%0d/%b, required 0101/2/0 then 1001/0/1",
                         obs_q[0].out, obs_q[0].idx, obs_q[0].last,
                         obs_q[1].out, obs_q[1].idx, obs_q[1].last);
            end
        end
    endtask

    task automatic test_all_zero();
        vec_t vec;
        for (int j = 0; j < VL; j++) vec[j] = '0;
        run_vector(1, vec, 2, 1'b0);
        n_checks++;
        if (obs_q.size() != 1) begin
            n_fail++;
            $display("FAIL zero_count: %0d transfers, required 1", obs_q.size());
        end else begin
            n_checks++;
            if ({obs_q[0].out, obs_q[0].idx, obs_q[0].last} !== {4'b0000, 3'd0, 1'b1}) begin
                n_fail++;
                $display("FAIL zero_plane: out=%b idx=%0d last=%b, required 0000 0 1",
                         obs_q[0].out, obs_q[0].idx, obs_q[0].last);
            end
        end
    endtask

    task automatic test_reset_mid();
        vec_t   vec;
        plane_t o;
        logic   v, lr, b;
        vec[0] = 8'h81; vec[1] = 8'h01; vec[2] = 8'h80; vec[3] = 8'hFF;
        drive_load(0, 1'b1, vec);
        @(posedge clk);
        @(negedge clk);
        lv0  = 1'b0;
        rdy0 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        rdy0  = 1'b0;
        observe(0, o, v, lr, b);
        n_checks++;
        if ({v, lr, b} !== 3'b010) begin
            n_fail++;
            $display("FAIL reset_abort: valid=%b load_ready=%b busy=%b, required 0 1 0", v, lr, b);
        end
        vec[0] = 8'hFF; vec[1] = 8'h00; vec[2] = 8'h00; vec[3] = 8'h00;
        run_vector(0, vec, 0, 1'b0);
        n_checks++;
        if ((obs_q.size() == 0) || ({obs_q[0].out, obs_q[0].idx} !== {4'b0001, 3'd7})) begin
            n_fail++;
            $display("FAIL reset_reload: first plane out=%b idx=%0d (n=%0d), required 0001 7",
                     (obs_q.size() > 0) ? obs_q[0].out : 4'bx,
                     (obs_q.size() > 0) ? obs_q[0].idx : 3'bx, obs_q.size());
        end
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 2; s++) begin
            run_vector(s, rand_vec(1'b1), 2, 1'b1);
            run_vector(s, rand_vec(1'b1), 0, 1'b1);
            run_vector(s, rand_vec(1'b0), 1, 1'b0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_vector(i % 2, rand_vec(1'($urandom_range(0, 1))), int'($urandom_range(0, 2)), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_full_stream();
        test_stall();
        test_zero_skip();
        test_all_zero();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
